// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA timing / test-pattern generator.
package vga_timing_pkg;

  // Pattern select codes; codes 5..7 give black with de still asserted.
  localparam logic [2:0] MODE_GRAD  = 3'd0;
  localparam logic [2:0] MODE_BARS  = 3'd1;
  localparam logic [2:0] MODE_CHECK = 3'd2;
  localparam logic [2:0] MODE_GRID  = 3'd3;
  localparam logic [2:0] MODE_SOLID = 3'd4;

  // Bar index -> {r,g,b} full-scale flags.
  // Order: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [2:0] bar_rgb_flags(input logic [2:0] idx);
    logic [2:0] f;
    case (idx)
      3'd0:    f = 3'b111;
      3'd1:    f = 3'b110;
      3'd2:    f = 3'b011;
      3'd3:    f = 3'b010;
      3'd4:    f = 3'b101;
      3'd5:    f = 3'b100;
      3'd6:    f = 3'b001;
      default: f = 3'b000;
    endcase
    return f;
  endfunction

  // Clocks per line / lines per frame from the four region widths.
  function automatic int raster_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_pattern_gen_if.sv
// Control inputs and video outputs of the pattern generator.
// master = generator side, slave = consumer (DAC pins / framebuffer logic).
interface vga_timing_pattern_gen_if #(
  parameter int COLOR_W = 8,
  parameter int X_W     = 10,
  parameter int Y_W     = 10
);
  logic                 en;
  logic [2:0]           mode;
  logic [3*COLOR_W-1:0] solid_rgb;
  logic                 vga_hs;
  logic                 vga_vs;
  logic                 vga_de;
  logic [COLOR_W-1:0]   vga_r;
  logic [COLOR_W-1:0]   vga_g;
  logic [COLOR_W-1:0]   vga_b;
  logic [X_W-1:0]       pix_x;
  logic [Y_W-1:0]       pix_y;
  logic                 frame_start;
  logic                 line_start;

  modport master (
    input  en, mode, solid_rgb,
    output vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b,
           pix_x, pix_y, frame_start, line_start
  );

  modport slave (
    output en, mode, solid_rgb,
    input  vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b,
           pix_x, pix_y, frame_start, line_start
  );
endinterface

// File: rtl/vga_sync_counter.sv
// Raster counters plus combinational sync/de/strobe decode.
// Everything here is pre-register; the top owns the output flops.
module vga_sync_counter import vga_timing_pkg::*; #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  localparam int H_TOTAL = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HC_W    = $clog2(H_TOTAL),
  localparam int VC_W    = $clog2(V_TOTAL)
) (
  input  logic            clk65M,
  input  logic            rstn,
  input  logic            i_en,
  output logic [HC_W-1:0] o_hcnt,
  output logic [VC_W-1:0] o_vcnt,
  output logic            o_hs,
  output logic            o_vs,
  output logic            o_de,
  output logic            o_frame_start,
  output logic            o_line_start,
  output logic            o_line_end
);
  localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOTAL - 1);
  localparam logic [HC_W-1:0] H_ACT  = HC_W'(H_ACTIVE);
  localparam logic [VC_W-1:0] V_ACT  = VC_W'(V_ACTIVE);
  localparam logic [HC_W-1:0] HS_BEG = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] HS_END = HC_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VC_W-1:0] VS_BEG = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] VS_END = VC_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic            HS_ON  = (HS_POL != 0);
  localparam logic            VS_ON  = (VS_POL != 0);

  logic [HC_W-1:0] r_hcnt;
  logic [VC_W-1:0] r_vcnt;
  logic            w_h_act, w_v_act, w_hs_on, w_vs_on, w_origin;

  // Raster position; en low parks it at the origin so a restart begins at (0,0).
  always_ff @(posedge clk65M or negedge rstn) begin
    if (!rstn) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (!i_en) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (r_hcnt == H_LAST) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  assign w_h_act  = (r_hcnt < H_ACT);
  assign w_v_act  = (r_vcnt < V_ACT);
  assign w_hs_on  = (r_hcnt >= HS_BEG) && (r_hcnt <= HS_END);
  // vcnt only moves at hcnt wrap, so vsync edges land on line boundaries.
  assign w_vs_on  = (r_vcnt >= VS_BEG) && (r_vcnt <= VS_END);
  assign w_origin = (r_hcnt == '0) && (r_vcnt == '0);

  assign o_hcnt        = r_hcnt;
  assign o_vcnt        = r_vcnt;
  assign o_hs          = (i_en && w_hs_on) ? HS_ON : ~HS_ON;
  assign o_vs          = (i_en && w_vs_on) ? VS_ON : ~VS_ON;
  assign o_de          = i_en && w_h_act && w_v_act;
  assign o_frame_start = i_en && w_origin;
  assign o_line_start  = i_en && (r_hcnt == '0) && w_v_act;
  assign o_line_end    = (r_hcnt == H_LAST);

endmodule

// File: rtl/vga_timing_pattern_gen.sv
// VGA raster timing master with frame-synchronous test patterns.
// All outputs come from one register stage fed by the same counter state.
module vga_timing_pattern_gen import vga_timing_pkg::*; #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int COLOR_W  = 8,
  parameter int NUM_BARS = 8,
  localparam int X_W     = $clog2(H_ACTIVE),
  localparam int Y_W     = $clog2(V_ACTIVE),
  localparam int HC_W    = $clog2(raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  localparam int VC_W    = $clog2(raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP)),
  localparam int BAR_W   = H_ACTIVE / NUM_BARS,
  localparam int BC_W    = (BAR_W > 1) ? $clog2(BAR_W) : 1
) (
  input  logic clk65M,
  input  logic rstn,
  vga_timing_pattern_gen_if.master bus
);
  localparam logic            HS_IDLE  = (HS_POL == 0);
  localparam logic            VS_IDLE  = (VS_POL == 0);
  localparam logic [BC_W-1:0] BAR_LAST = BC_W'(BAR_W - 1);
  localparam logic [HC_W-1:0] X_LAST   = HC_W'(H_ACTIVE - 1);
  localparam logic [VC_W-1:0] Y_LAST   = VC_W'(V_ACTIVE - 1);

  logic [HC_W-1:0]      w_hcnt;
  logic [VC_W-1:0]      w_vcnt;
  logic                 w_hs, w_vs, w_de, w_fs, w_ls, w_line_end;
  logic [2:0]           w_mode, w_bar_flags;
  logic [5:0]           w_x6, w_y6;
  logic                 w_grid_on;
  logic [3*COLOR_W-1:0] w_rgb;

  logic [2:0]           r_mode_q;
  logic [BC_W-1:0]      r_bar_cnt;
  logic [2:0]           r_bar_idx;
  logic                 r_hs, r_vs, r_de, r_fs, r_ls;
  logic [3*COLOR_W-1:0] r_rgb;
  logic [X_W-1:0]       r_pix_x;
  logic [Y_W-1:0]       r_pix_y;

  vga_sync_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_sync (
    .clk65M        (clk65M),
    .rstn          (rstn),
    .i_en          (bus.en),
    .o_hcnt        (w_hcnt),
    .o_vcnt        (w_vcnt),
    .o_hs          (w_hs),
    .o_vs          (w_vs),
    .o_de          (w_de),
    .o_frame_start (w_fs),
    .o_line_start  (w_ls),
    .o_line_end    (w_line_end)
  );

  // Latch the pattern select only at the raster origin.
  always_ff @(posedge clk65M or negedge rstn) begin
    if (!rstn)                              r_mode_q <= '0;
    else if (w_hcnt == '0 && w_vcnt == '0)  r_mode_q <= bus.mode;
  end

  // Pixel (0,0) already belongs to the new frame, so it sees the live mode.
  assign w_mode = (w_hcnt == '0 && w_vcnt == '0) ? bus.mode : r_mode_q;

  // Colour-bar position tracked by a width sub-counter instead of x / BAR_W.
  always_ff @(posedge clk65M or negedge rstn) begin
    if (!rstn) begin
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else if (!bus.en || w_line_end) begin
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else if (w_de) begin
      if (r_bar_cnt == BAR_LAST) begin
        r_bar_cnt <= '0;
        r_bar_idx <= r_bar_idx + 1'b1;
      end else begin
        r_bar_cnt <= r_bar_cnt + 1'b1;
      end
    end
  end

  assign w_bar_flags = bar_rgb_flags(r_bar_idx);
  assign w_x6        = 6'(w_hcnt);
  assign w_y6        = 6'(w_vcnt);
  assign w_grid_on   = (w_x6 == '0) || (w_y6 == '0) || (w_hcnt == X_LAST) || (w_vcnt == Y_LAST);

  // Pattern colour for the current counter position; blanking forces black.
  always_comb begin
    w_rgb = '0;
    case (w_mode)
      MODE_GRAD:  w_rgb = {3{COLOR_W'(w_hcnt)}};
      MODE_BARS:  w_rgb = {{COLOR_W{w_bar_flags[2]}}, {COLOR_W{w_bar_flags[1]}},
                           {COLOR_W{w_bar_flags[0]}}};
      MODE_CHECK: w_rgb = {(3*COLOR_W){w_x6[5] ^ w_y6[5]}};
      MODE_GRID:  w_rgb = {(3*COLOR_W){w_grid_on}};
      MODE_SOLID: w_rgb = bus.solid_rgb;
      default:    w_rgb = '0;
    endcase
    if (!w_de) w_rgb = '0;
  end

  // Output stage; pixel coordinates hold their last active value in blanking.
  always_ff @(posedge clk65M or negedge rstn) begin
    if (!rstn) begin
      r_hs    <= HS_IDLE;
      r_vs    <= VS_IDLE;
      r_de    <= 1'b0;
      r_fs    <= 1'b0;
      r_ls    <= 1'b0;
      r_rgb   <= '0;
      r_pix_x <= '0;
      r_pix_y <= '0;
    end else begin
      r_hs  <= w_hs;
      r_vs  <= w_vs;
      r_de  <= w_de;
      r_fs  <= w_fs;
      r_ls  <= w_ls;
      r_rgb <= w_rgb;
      if (w_de) begin
        r_pix_x <= w_hcnt[X_W-1:0];
        r_pix_y <= w_vcnt[Y_W-1:0];
      end
    end
  end

  assign bus.vga_hs      = r_hs;
  assign bus.vga_vs      = r_vs;
  assign bus.vga_de      = r_de;
  assign bus.vga_r       = r_rgb[3*COLOR_W-1:2*COLOR_W];
  assign bus.vga_g       = r_rgb[2*COLOR_W-1:COLOR_W];
  assign bus.vga_b       = r_rgb[COLOR_W-1:0];
  assign bus.pix_x       = r_pix_x;
  assign bus.pix_y       = r_pix_y;
  assign bus.frame_start = r_fs;
  assign bus.line_start  = r_ls;

endmodule
